mem_wb_stage: RTL and testbench

- MEM/WB pipeline register plus writeback result selection for the 5-stage MIPS core.
- Captures the MEM-stage control and data on the rising clock edge.
- Performs load byte/halfword extraction and alignment checking.
- Drives the register file write port (we3/wa3/wd3); the register file commits on the falling edge of the same cycle.
- Also provides a retired-instruction counter for the hazard/debug logic.

---
 rtl/mem_wb_stage.sv | 146 ++++++++++++++
 tb/tb_mem_wb_stage.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load extraction, alignment checking and
// register-file write port generation; also counts retired instructions.
module mem_wb_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_valid,
    input  logic              mem_regwrite,
    input  logic              mem_memtoreg,
    input  logic [2:0]        mem_loadtype,
    input  logic [4:0]        mem_writereg,
    input  logic [DATA_W-1:0] mem_aluout,
    input  logic [DATA_W-1:0] mem_readdata,
    input  logic              stall_w,
    input  logic              flush_w,
    output logic              we3,
    output logic [4:0]        wa3,
    output logic [DATA_W-1:0] wd3,
    output logic              valid_w,
    output logic              addr_err_w,
    output logic [CNT_W-1:0]  retired_cnt
);

    localparam logic [2:0] LT_LB  = 3'b001;
    localparam logic [2:0] LT_LBU = 3'b010;
    localparam logic [2:0] LT_LH  = 3'b011;
    localparam logic [2:0] LT_LHU = 3'b100;

    logic              r_valid;
    logic              r_regwrite;
    logic              r_memtoreg;
    logic [2:0]        r_loadtype;
    logic [4:0]        r_writereg;
    logic [DATA_W-1:0] r_aluout;
    logic [DATA_W-1:0] r_readdata;
    logic [CNT_W-1:0]  r_cnt;

    logic [DATA_W-1:0] w_load_data;
    logic              w_misaligned;
    logic              w_addr_err;

    // Little-endian lane extraction; unknown load codes fall back to a full word.
    function automatic logic [DATA_W-1:0] f_load_format(
        input logic [2:0]        lt,
        input logic [1:0]        a,
        input logic [DATA_W-1:0] d
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [DATA_W-1:0] res;
        case (a)
            2'b00:   b = d[7:0];
            2'b01:   b = d[15:8];
            2'b10:   b = d[23:16];
            2'b11:   b = d[31:24];
            default: b = d[7:0];
        endcase
        if (a[1]) begin
            h = d[31:16];
        end else begin
            h = d[15:0];
        end
        case (lt)
            LT_LB:   res = {{(DATA_W-8){b[7]}}, b};
            LT_LBU:  res = {{(DATA_W-8){1'b0}}, b};
            LT_LH:   res = {{(DATA_W-16){h[15]}}, h};
            LT_LHU:  res = {{(DATA_W-16){1'b0}}, h};
            default: res = d;
        endcase
        return res;
    endfunction

    function automatic logic f_misaligned(input logic [2:0] lt, input logic [1:0] a);
        logic res;
        case (lt)
            LT_LB, LT_LBU: res = 1'b0;
            LT_LH, LT_LHU: res = a[0];
            default:       res = (a != 2'b00);
        endcase
        return res;
    endfunction

    // WB pipeline register: reset, then flush, then stall, then capture.
    always_ff @(posedge clk) begin
        if (rst || flush_w) begin
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
            r_memtoreg <= 1'b0;
            r_loadtype <= 3'b000;
            r_writereg <= 5'd0;
            r_aluout   <= {DATA_W{1'b0}};
            r_readdata <= {DATA_W{1'b0}};
        end else if (stall_w) begin
            r_valid    <= r_valid;
            r_regwrite <= r_regwrite;
            r_memtoreg <= r_memtoreg;
            r_loadtype <= r_loadtype;
            r_writereg <= r_writereg;
            r_aluout   <= r_aluout;
            r_readdata <= r_readdata;
        end else begin
            r_valid    <= mem_valid;
            r_regwrite <= mem_regwrite;
            r_memtoreg <= mem_memtoreg;
            r_loadtype <= mem_loadtype;
            r_writereg <= mem_writereg;
            r_aluout   <= mem_aluout;
            r_readdata <= mem_readdata;
        end
    end

    // Retire counter: the instruction leaving WB counts even if it is being flushed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (r_valid && !stall_w) begin
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // Writeback data selection and alignment fault detection.
    always_comb begin
        w_load_data  = f_load_format(r_loadtype, r_aluout[1:0], r_readdata);
        w_misaligned = f_misaligned(r_loadtype, r_aluout[1:0]);
        w_addr_err   = r_valid & r_memtoreg & w_misaligned;
    end

    // Register-file port; a faulting load or a write to $0 never commits.
    always_comb begin
        we3 = r_valid & r_regwrite & (r_writereg != 5'd0) & ~w_addr_err;
        wa3 = r_writereg;
        if (r_memtoreg) begin
            wd3 = w_load_data;
        end else begin
            wd3 = r_aluout;
        end
        valid_w     = r_valid;
        addr_err_w  = w_addr_err;
        retired_cnt = r_cnt;
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage; a second CNT_W=4 instance
// shares the stimulus to exercise retire-counter wrap.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid, mem_regwrite, mem_memtoreg;
    logic [2:0]  mem_loadtype;
    logic [4:0]  mem_writereg;
    logic [31:0] mem_aluout, mem_readdata;
    logic        stall_w, flush_w;

    logic        we3, valid_w, addr_err_w;
    logic [4:0]  wa3;
    logic [31:0] wd3, retired_cnt;

    logic        we3_4, valid_w_4, addr_err_w_4;
    logic [4:0]  wa3_4;
    logic [31:0] wd3_4;
    logic [3:0]  cnt_4;

    int n_tests = 0;
    int n_fail  = 0;

    logic        exp_valid = 1'b0;
    logic [31:0] exp_cnt   = 32'd0;

    always #5 clk = ~clk;

    mem_wb_stage #(.DATA_W(32), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_regwrite(mem_regwrite),
        .mem_memtoreg(mem_memtoreg), .mem_loadtype(mem_loadtype),
        .mem_writereg(mem_writereg), .mem_aluout(mem_aluout),
        .mem_readdata(mem_readdata), .stall_w(stall_w), .flush_w(flush_w),
        .we3(we3), .wa3(wa3), .wd3(wd3), .valid_w(valid_w),
        .addr_err_w(addr_err_w), .retired_cnt(retired_cnt)
    );

    mem_wb_stage #(.DATA_W(32), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_regwrite(mem_regwrite),
        .mem_memtoreg(mem_memtoreg), .mem_loadtype(mem_loadtype),
        .mem_writereg(mem_writereg), .mem_aluout(mem_aluout),
        .mem_readdata(mem_readdata), .stall_w(stall_w), .flush_w(flush_w),
        .we3(we3_4), .wa3(wa3_4), .wd3(wd3_4), .valid_w(valid_w_4),
        .addr_err_w(addr_err_w_4), .retired_cnt(cnt_4)
    );

    task automatic drive(input logic v, input logic rw, input logic m2r,
                         input logic [2:0] lt, input logic [4:0] wr,
                         input logic [31:0] alu, input logic [31:0] rd);
        mem_valid = v; mem_regwrite = rw; mem_memtoreg = m2r;
        mem_loadtype = lt; mem_writereg = wr; mem_aluout = alu; mem_readdata = rd;
    endtask

    // One clock edge; keeps the expected valid/retire-count model in step.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            exp_valid = 1'b0;
            exp_cnt   = 32'd0;
        end else begin
            if (exp_valid && !stall_w) exp_cnt = exp_cnt + 32'd1;
            if (flush_w)       exp_valid = 1'b0;
            else if (!stall_w) exp_valid = mem_valid;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall_w = 1'b0; flush_w = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 3'b000, 5'd3, 32'h0000_00AA, 32'h0);
        for (int i = 0; i < 2; i++) begin
            tick();
            n_tests++;
            if (we3 !== 1'b0 || valid_w !== 1'b0 || retired_cnt !== 32'd0 || wd3 !== 32'd0
                || wa3 !== 5'd0 || addr_err_w !== 1'b0) begin
                n_fail++;
                $display("FAIL reset cyc%0d: we3=%b valid=%b cnt=%0d wa3=%0d wd3=%h err=%b, want all 0",
                         i, we3, valid_w, retired_cnt, wa3, wd3, addr_err_w);
            end
        end
        rst = 1'b0;
        tick();
        n_tests++;
        if (valid_w !== 1'b1 || we3 !== 1'b1 || wa3 !== 5'd3 || wd3 !== 32'h0000_00AA
            || retired_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_first_capture: valid=%b we3=%b wa3=%0d wd3=%h cnt=%0d, want 1 1 3 000000aa 0",
                     valid_w, we3, wa3, wd3, retired_cnt);
        end
        drive(1'b0, 1'b0, 1'b0, 3'b000, 5'd0, 32'h0, 32'h0);
        tick();
        n_tests++;
        if (retired_cnt !== 32'd1 || valid_w !== 1'b0 || we3 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_first_retire: cnt=%0d valid=%b we3=%b, want 1 0 0",
                     retired_cnt, valid_w, we3);
        end
    endtask

    task automatic test_alu();
        drive(1'b1, 1'b1, 1'b0, 3'b000, 5'd5, 32'h1234_5678, 32'hDEAD_BEEF);
        tick();
        n_tests++;
        if (we3 !== 1'b1 || wa3 !== 5'd5 || wd3 !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL alu_wb: we3=%b wa3=%0d wd3=%h, want 1 5 12345678", we3, wa3, wd3);
        end
        drive(1'b1, 1'b1, 1'b0, 3'b000, 5'd0, 32'h1234_5678, 32'h0);
        tick();
        n_tests++;
        if (we3 !== 1'b0 || wa3 !== 5'd0 || valid_w !== 1'b1 || retired_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL alu_r0: we3=%b wa3=%0d valid=%b cnt=%0d, want 0 0 1 %0d",
                     we3, wa3, valid_w, retired_cnt, exp_cnt);
        end
    endtask

    task automatic test_loads();
        logic [2:0]  lt  [6] = '{3'b001, 3'b001, 3'b010, 3'b011, 3'b100, 3'b000};
        logic [1:0]  ad  [6] = '{2'b01, 2'b10, 2'b11, 2'b10, 2'b00, 2'b00};
        logic [31:0] exp [6] = '{32'h0000_007F, 32'hFFFF_FFFF, 32'h0000_0080,
                                 32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01};
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1, 1'b1, lt[i], 5'd7, {28'h0000_100, 2'b00, ad[i]}, 32'h80FF_7F01);
            tick();
            n_tests++;
            if (wd3 !== exp[i] || we3 !== 1'b1 || addr_err_w !== 1'b0 || wa3 !== 5'd7) begin
                n_fail++;
                $display("FAIL load%0d lt=%b a=%b: wd3=%h we3=%b err=%b wa3=%0d, want %h 1 0 7",
                         i, lt[i], ad[i], wd3, we3, addr_err_w, wa3, exp[i]);
            end
        end
    endtask

    task automatic test_misaligned();
        logic [2:0]  lt [2] = '{3'b011, 3'b000};
        logic [31:0] a  [2] = '{32'h0000_1001, 32'h0000_1002};
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 1'b1, lt[i], 5'd8, a[i], 32'h1111_2222);
            tick();
            n_tests++;
            if (addr_err_w !== 1'b1 || we3 !== 1'b0 || valid_w !== 1'b1) begin
                n_fail++;
                $display("FAIL misalign%0d: err=%b we3=%b valid=%b, want 1 0 1",
                         i, addr_err_w, we3, valid_w);
            end
            drive(1'b0, 1'b0, 1'b0, 3'b000, 5'd0, 32'h0, 32'h0);
            tick();
            n_tests++;
            if (retired_cnt !== exp_cnt || addr_err_w !== 1'b0) begin
                n_fail++;
                $display("FAIL misalign%0d_retire: cnt=%0d err=%b, want %0d 0",
                         i, retired_cnt, addr_err_w, exp_cnt);
            end
        end
        // Odd address on an ALU result is not a load, so no fault.
        drive(1'b1, 1'b1, 1'b0, 3'b000, 5'd9, 32'h0000_1003, 32'h0);
        tick();
        n_tests++;
        if (addr_err_w !== 1'b0 || we3 !== 1'b1 || wd3 !== 32'h0000_1003) begin
            n_fail++;
            $display("FAIL misalign_alu: err=%b we3=%b wd3=%h, want 0 1 00001003",
                     addr_err_w, we3, wd3);
        end
    endtask

    task automatic test_stall();
        logic [31:0] cnt0;
        drive(1'b1, 1'b1, 1'b0, 3'b000, 5'd9, 32'h0000_0055, 32'h0);
        tick();
        cnt0 = exp_cnt;
        stall_w = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 3'b000, 5'd12, 32'hCAFE_0000, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (we3 !== 1'b1 || wa3 !== 5'd9 || wd3 !== 32'h0000_0055 || retired_cnt !== cnt0) begin
                n_fail++;
                $display("FAIL stall%0d: we3=%b wa3=%0d wd3=%h cnt=%0d, want 1 9 00000055 %0d",
                         i, we3, wa3, wd3, retired_cnt, cnt0);
            end
        end
        stall_w = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 3'b000, 5'd0, 32'h0, 32'h0);
        tick();
        n_tests++;
        if (retired_cnt !== cnt0 + 32'd1 || valid_w !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_release: cnt=%0d valid=%b, want %0d 0",
                     retired_cnt, valid_w, cnt0 + 32'd1);
        end
    endtask

    task automatic test_flush();
        logic [31:0] cnt0;
        drive(1'b1, 1'b1, 1'b0, 3'b000, 5'd4, 32'h0000_0044, 32'h0);
        tick();
        cnt0 = exp_cnt;
        flush_w = 1'b1; stall_w = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 3'b000, 5'd6, 32'h0000_0066, 32'h0);
        tick();
        n_tests++;
        if (valid_w !== 1'b0 || we3 !== 1'b0 || retired_cnt !== cnt0) begin
            n_fail++;
            $display("FAIL flush_stall: valid=%b we3=%b cnt=%0d, want 0 0 %0d",
                     valid_w, we3, retired_cnt, cnt0);
        end
        flush_w = 1'b0; stall_w = 1'b0;
        tick();
        flush_w = 1'b1;
        tick();
        n_tests++;
        if (valid_w !== 1'b0 || we3 !== 1'b0 || retired_cnt !== cnt0 + 32'd1) begin
            n_fail++;
            $display("FAIL flush_counts: valid=%b we3=%b cnt=%0d, want 0 0 %0d",
                     valid_w, we3, retired_cnt, cnt0 + 32'd1);
        end
        flush_w = 1'b0;
    endtask

    task automatic test_back_to_back_wrap();
        logic [3:0] want [3] = '{4'd15, 4'd0, 4'd1};
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            drive(1'b1, 1'b1, 1'b0, 3'b000, 5'd1 + 5'(i % 30), 32'(i), 32'h0);
            tick();
        end
        n_tests++;
        if (cnt_4 !== 4'd14 || retired_cnt !== 32'd14) begin
            n_fail++;
            $display("FAIL wrap_pre: cnt4=%0d cnt=%0d, want 14 14", cnt_4, retired_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, 3'b000, 5'd20, 32'h0000_0BB0 + 32'(i), 32'h0);
            tick();
            n_tests++;
            if (cnt_4 !== want[i] || retired_cnt !== exp_cnt || valid_w_4 !== 1'b1
                || we3_4 !== 1'b1 || wa3_4 !== 5'd20 || wd3_4 !== 32'h0000_0BB0 + 32'(i)
                || addr_err_w_4 !== 1'b0) begin
                n_fail++;
                $display("FAIL wrap%0d: cnt4=%0d cnt=%0d v4=%b we4=%b wa4=%0d wd4=%h err4=%b, want %0d %0d 1 1 20 %h 0",
                         i, cnt_4, retired_cnt, valid_w_4, we3_4, wa3_4, wd3_4, addr_err_w_4,
                         want[i], exp_cnt, 32'h0000_0BB0 + 32'(i));
            end
        end
        // Reset mid-stream discards the WB instruction and clears the counter.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++;
        if (we3 !== 1'b0 || valid_w !== 1'b0 || retired_cnt !== 32'd0 || cnt_4 !== 4'd0) begin
            n_fail++;
            $display("FAIL mid_reset: we3=%b valid=%b cnt=%0d cnt4=%0d, want 0 0 0 0",
                     we3, valid_w, retired_cnt, cnt_4);
        end
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 3'b000, 5'd0, 32'h0, 32'h0);
        rst = 1'b1; stall_w = 1'b0; flush_w = 1'b0;
        #1;
        test_reset();
        test_alu();
        test_loads();
        test_misaligned();
        test_stall();
        test_flush();
        test_back_to_back_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
